fact_job_scheduler: RTL

FACT_JOB_SCHEDULER -- requirements
Module: fact_job_scheduler

---
 rtl/fact_sched_pkg.sv | 17 +
 rtl/fact_job_scheduler_rr_arbiter.sv | 38 +++
 rtl/fact_job_scheduler.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/fact_sched_pkg.sv
// Shared widths, defaults and state encoding for the factorial-sum job scheduler.
package fact_sched_pkg;

    localparam int unsigned N_W         = 3;
    localparam int unsigned RES_W       = 13;
    localparam int unsigned DEF_NREQ    = 4;
    localparam int unsigned DEF_TIMEOUT = 64;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ISSUE = 3'd1,
        ST_WAIT  = 3'd2,
        ST_ACK   = 3'd3,
        ST_RESP  = 3'd4
    } state_e;

endpackage

// File: rtl/fact_job_scheduler_rr_arbiter.sv
// Round-robin arbiter: the search starts one past ptr_i and wraps, yielding a one-hot
// grant and its encoded index.
module rr_arbiter #(
    parameter int unsigned NREQ  = 4,
    parameter int unsigned IDX_W = 2
) (
    input  logic [NREQ-1:0]  req_i,
    input  logic [IDX_W-1:0] ptr_i,
    input  logic             en_i,
    output logic [NREQ-1:0]  gnt_o,
    output logic [IDX_W-1:0] idx_o,
    output logic             valid_o
);

    int unsigned      cand;
    logic [IDX_W-1:0] cand_idx;

    always_comb begin
        gnt_o    = '0;
        idx_o    = '0;
        valid_o  = 1'b0;
        cand     = 0;
        cand_idx = '0;
        if (en_i) begin
            // k runs from 1 to NREQ, so the last candidate tried is ptr_i itself.
            for (int unsigned k = 1; k <= NREQ; k++) begin
                cand     = (32'(ptr_i) + k) % NREQ;
                cand_idx = IDX_W'(cand);
                if (!valid_o && req_i[cand_idx]) begin
                    valid_o         = 1'b1;
                    gnt_o[cand_idx] = 1'b1;
                    idx_o           = cand_idx;
                end
            end
        end
    end

endmodule

// File: rtl/fact_job_scheduler.sv
// Time-shares one sum_fact_N engine among NREQ requesters, with one job in flight at a time,
// round-robin grants, N=0 rejection and a WAIT-state timeout.
module fact_job_scheduler
    import fact_sched_pkg::*;
#(
    parameter int unsigned NREQ    = DEF_NREQ,
    parameter int unsigned TIMEOUT = DEF_TIMEOUT
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NREQ-1:0]          req_valid,
    input  logic [3*NREQ-1:0]        req_n,
    output logic [NREQ-1:0]          req_ready,
    output logic                     rsp_valid,
    output logic [$clog2(NREQ)-1:0]  rsp_id,
    output logic [RES_W-1:0]         rsp_data,
    output logic                     rsp_err,
    input  logic                     rsp_ready,
    output logic [N_W-1:0]           eng_n_in,
    output logic                     eng_input_valid,
    output logic                     eng_output_ack,
    input  logic [RES_W-1:0]         eng_sum,
    input  logic                     eng_output_valid
);

    localparam int unsigned IDX_W = $clog2(NREQ);
    localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

    state_e             state_q, state_d;
    logic [IDX_W-1:0]   ptr_q,   ptr_d;
    logic [IDX_W-1:0]   id_q,    id_d;
    logic [N_W-1:0]     n_q,     n_d;
    logic [RES_W-1:0]   data_q,  data_d;
    logic               err_q,   err_d;
    logic [CNT_W-1:0]   cnt_q,   cnt_d;

    logic [NREQ-1:0]    gnt;
    logic [IDX_W-1:0]   gnt_idx;
    logic               gnt_any;
    logic               arb_en;
    logic [N_W-1:0]     sel_n;

    // Gating with reset keeps req_ready low while reset is held, even with requests pending.
    assign arb_en = (state_q == ST_IDLE) && !reset;

    rr_arbiter #(
        .NREQ  (NREQ),
        .IDX_W (IDX_W)
    ) u_arb (
        .req_i   (req_valid),
        .ptr_i   (ptr_q),
        .en_i    (arb_en),
        .gnt_o   (gnt),
        .idx_o   (gnt_idx),
        .valid_o (gnt_any)
    );

    always_comb begin
        sel_n = req_n[32'(gnt_idx)*N_W +: N_W];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            ptr_q   <= IDX_W'(NREQ - 1);
            id_q    <= '0;
            n_q     <= '0;
            data_q  <= '0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            id_q    <= id_d;
            n_q     <= n_d;
            data_q  <= data_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d         = state_q;
        ptr_d           = ptr_q;
        id_d            = id_q;
        n_d             = n_q;
        data_d          = data_q;
        err_d           = err_q;
        cnt_d           = cnt_q;
        req_ready       = '0;
        rsp_valid       = 1'b0;
        rsp_id          = '0;
        rsp_data        = '0;
        rsp_err         = 1'b0;
        eng_n_in        = '0;
        eng_input_valid = 1'b0;
        eng_output_ack  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (gnt_any) begin
                    req_ready = gnt;
                    ptr_d     = gnt_idx;
                    id_d      = gnt_idx;
                    n_d       = sel_n;
                    data_d    = '0;
                    // The engine never finishes on N=0, so such jobs bypass it entirely.
                    if (sel_n == '0) begin
                        err_d   = 1'b1;
                        state_d = ST_RESP;
                    end else begin
                        err_d   = 1'b0;
                        state_d = ST_ISSUE;
                    end
                end
            end
            ST_ISSUE: begin
                eng_input_valid = 1'b1;
                eng_n_in        = n_q;
                cnt_d           = '0;
                state_d         = ST_WAIT;
            end
            ST_WAIT: begin
                if (eng_output_valid) begin
                    data_d  = eng_sum;
                    err_d   = 1'b0;
                    state_d = ST_ACK;
                end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    data_d  = '0;
                    err_d   = 1'b1;
                    state_d = ST_RESP;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_ACK: begin
                eng_output_ack = 1'b1;
                state_d        = ST_RESP;
            end
            ST_RESP: begin
                rsp_valid = 1'b1;
                rsp_id    = id_q;
                rsp_data  = data_q;
                rsp_err   = err_q;
                if (rsp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

endmodule
